// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding RAM responder with configurable access latency
module mem_responder #(
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [63:0] cap_addr;
    logic        cap_wen;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wmask;
    logic [63:0] mem [DEPTH];

    logic [60:0]           word_off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  perform;
    logic                  resp_done;

    // Word offset from BASE; the >= guard keeps below-BASE addresses from wrapping into range.
    assign word_off  = 61'((cap_addr - BASE) >> 3);
    assign in_range  = (cap_addr >= BASE) && ((word_off >> DEPTH_LOG2) == 61'd0);
    assign idx       = word_off[DEPTH_LOG2-1:0];
    assign accept    = (state == IDLE) && req_valid;
    assign perform   = (state == WAIT) && (cnt == 4'd0);
    assign resp_done = (state == RESP) && resp_ready;

    // Next-state and latency counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
        end
    end

    // Request capture; inputs are only sampled on the accept handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr  <= 64'd0;
            cap_wen   <= 1'b0;
            cap_wdata <= 64'd0;
            cap_wmask <= 8'd0;
        end else if (accept) begin
            cap_addr  <= req_addr;
            cap_wen   <= req_wen;
            cap_wdata <= req_wdata;
            cap_wmask <= req_wmask;
        end
    end

    // Response payload: loaded at the perform edge, cleared when the initiator takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else if (perform) begin
            resp_rdata <= (in_range && !cap_wen) ? mem[idx] : 64'd0;
            resp_err   <= !in_range;
        end else if (resp_done) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end
    end

    // Byte-masked RAM write, applied once at the perform edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (perform && in_range && cap_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (cap_wmask[i]) begin
                    mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 2 and 4
module tb_mem_responder;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_ready;

    logic        req_valid0, req_ready0, resp_valid0, resp_err0;
    logic [63:0] resp_rdata0;
    logic        req_valid1, req_ready1, resp_valid1, resp_err1;
    logic [63:0] resp_rdata1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc;
    int   checks;
    int   errors;
    logic pv0, pv1;

    mem_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    mem_responder #(.LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the LATENCY=2 instance: latency on rising valid, payload at handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (resp_valid0 && !pv0) begin
                if (q0.size() == 0) chk("dut0_unexpected_resp", 1, 0);
                else chk("dut0_latency", 64'(cyc), 64'(q0[0].due));
            end
            if (resp_valid0 && resp_ready && q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_rdata", resp_rdata0, e.rdata);
                chk("dut0_err", 64'(resp_err0), 64'(e.err));
            end
        end
        pv0 = resp_valid0;
    end

    // Monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        if (rst) begin
            if (resp_valid1 && !pv1) begin
                if (q1.size() == 0) chk("dut1_unexpected_resp", 1, 0);
                else chk("dut1_latency", 64'(cyc), 64'(q1[0].due));
            end
            if (resp_valid1 && resp_ready && q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_rdata", resp_rdata1, e.rdata);
                chk("dut1_err", 64'(resp_err1), 64'(e.err));
            end
        end
        pv1 = resp_valid1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int sel, input logic [63:0] addr, input logic wen,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic push, input logic [63:0] exp_rdata, input logic exp_err);
        bit   done;
        exp_t e;
        done      = 0;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wmask = wmask;
        if (sel == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if ((sel == 0) ? req_ready0 : req_ready1) done = 1;
            step();
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        if (!done) begin
            chk("req_accept_timeout", 0, 1);
        end else if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cyc + ((sel == 0) ? 2 : 4);
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic wait_idle(input int sel);
        bit done;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            if (sel == 0) done = (q0.size() == 0) && req_ready0;
            else          done = (q1.size() == 0) && req_ready1;
            if (!done) step();
        end
        if (!done) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        pv0        = 0;
        pv1        = 0;
        rst        = 1'b0;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_addr   = 64'd0;
        req_wen    = 1'b0;
        req_wdata  = 64'd0;
        req_wmask  = 8'd0;
        resp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        chk("rst_req_ready", 64'(req_ready0), 1);
        chk("rst_resp_valid", 64'(resp_valid0), 0);
        chk("rst_resp_rdata", resp_rdata0, 0);
        chk("rst_resp_err", 64'(resp_err0), 0);
        chk("rst1_req_ready", 64'(req_ready1), 1);
        step();

        // Full writes, readback, partial mask, no-op mask, upper boundary.
        do_req(0, 64'h8000_0000, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'd0, 0); wait_idle(0);
        do_req(0, 64'h8000_0010, 1, 64'h1122_3344_5566_7788, 8'hFF, 1, 64'd0, 0); wait_idle(0);
        do_req(0, 64'h8000_0010, 0, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 0); wait_idle(0);
        do_req(0, 64'h8000_0010, 1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, 64'd0, 0); wait_idle(0);
        do_req(0, 64'h8000_0014, 0, 64'd0, 8'h00, 1, 64'h1122_3344_AAAA_AAAA, 0); wait_idle(0);
        do_req(0, 64'h8000_0010, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 64'd0, 0); wait_idle(0);
        do_req(0, 64'h8000_7FF8, 1, 64'hCAFE_F00D_0000_BEEF, 8'hFF, 1, 64'd0, 0); wait_idle(0);
        do_req(0, 64'h8000_7FF8, 0, 64'd0, 8'h00, 1, 64'hCAFE_F00D_0000_BEEF, 0); wait_idle(0);

        // Out of range below BASE and one word past the end.
        do_req(0, 64'h7FFF_FFF8, 0, 64'd0, 8'h00, 1, 64'd0, 1); wait_idle(0);
        do_req(0, 64'h8000_8000, 1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1, 64'd0, 1); wait_idle(0);
        do_req(0, 64'h8000_0000, 0, 64'd0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 0); wait_idle(0);

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        do_req(0, 64'h8000_0010, 0, 64'd0, 8'h00, 1, 64'h1122_3344_AAAA_AAAA, 0);
        for (int n = 0; n < 20 && !resp_valid0; n++) step();
        for (int n = 0; n < 5; n++) begin
            chk("bp_resp_valid", 64'(resp_valid0), 1);
            chk("bp_rdata", resp_rdata0, 64'h1122_3344_AAAA_AAAA);
            chk("bp_req_ready", 64'(req_ready0), 0);
            step();
        end
        resp_ready = 1'b1;
        step();
        chk("bp_after_valid", 64'(resp_valid0), 0);
        chk("bp_after_ready", 64'(req_ready0), 1);
        chk("bp_after_rdata", resp_rdata0, 0);
        wait_idle(0);

        // Reset during WAIT on the LATENCY=4 instance aborts the pending write.
        do_req(1, 64'h8000_0020, 1, 64'h5555, 8'hFF, 1, 64'd0, 0); wait_idle(1);
        do_req(1, 64'h8000_0020, 1, 64'hDEAD, 8'hFF, 0, 64'd0, 0);
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("abort_no_resp", 64'(resp_valid1), 0);
            step();
        end
        rst = 1'b1;
        chk("abort_req_ready", 64'(req_ready1), 1);
        for (int n = 0; n < 4; n++) begin
            chk("abort_no_resp_after", 64'(resp_valid1), 0);
            step();
        end
        do_req(1, 64'h8000_0020, 0, 64'd0, 8'h00, 1, 64'h5555, 0); wait_idle(1);

        step();
        chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
